// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response codes, FSM encodings and helpers
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_slave_ram_if.sv
// rtl/axi_slave_ram_if.sv - AXI4 AW/W/B/AR/R channel bundle with master and slave views
interface axi_slave_ram_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_slave_ram_mem.sv
// rtl/axi_slave_ram_mem.sv - dual-port RAM, byte-enable write port, read port fed by a registered index
module axi_slave_ram_mem
  import axi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int IDX_W = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]   raddr,
  output logic [WIDTH-1:0]   rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // raddr is a register in the caller, so a write is seen on the following cycle
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI4 slave with word-addressed RAM, independent single-outstanding write and read FSMs
module axi_slave_ram
  import axi_pkg::*;
#(
  parameter int                  S_ADDR_WIDTH = 32,
  parameter logic [S_ADDR_WIDTH-1:0] S_BASE_ADDR = 32'h4000_0000,
  parameter int                  S_ID_WIDTH   = 1,
  parameter int                  S_DATA_WIDTH = 32,
  parameter int                  S_MEM_DEPTH  = 256
) (
  input  logic           clk,
  input  logic           rst,
  axi_slave_ram_if.slave s_axi
);
  localparam int BYTES = S_DATA_WIDTH / 8;
  localparam int OFF_W = clog2(BYTES);
  localparam int IDX_W = clog2(S_MEM_DEPTH);
  localparam logic [S_ADDR_WIDTH-1:0] MEM_BYTES = S_ADDR_WIDTH'(S_MEM_DEPTH * BYTES);

  function automatic logic [IDX_W-1:0] word_idx(input logic [S_ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - S_BASE_ADDR) >> OFF_W);
  endfunction

  function automatic logic out_of_range(input logic [S_ADDR_WIDTH-1:0] addr);
    return (addr - S_BASE_ADDR) >= MEM_BYTES;
  endfunction

  logic             size_unused;
  assign size_unused = ^{s_axi.awsize, s_axi.arsize};

  logic [1:0]       w_state;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_len, w_cnt;
  logic             w_fixed, w_dec, w_over;

  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_len, r_cnt;
  logic             r_fixed, r_dec;

  logic [S_DATA_WIDTH-1:0] mem_rdata;
  logic                    mem_we;

  assign mem_we = s_axi.wvalid && s_axi.wready && !w_dec;

  axi_slave_ram_mem #(.DEPTH(S_MEM_DEPTH), .WIDTH(S_DATA_WIDTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .raddr (r_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bid     <= '0;
      s_axi.bresp   <= RESP_OKAY;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_fixed       <= 1'b0;
      w_dec         <= 1'b0;
      w_over        <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awvalid && s_axi.awready) begin
            s_axi.awready <= 1'b0;
            s_axi.wready  <= 1'b1;
            s_axi.bid     <= s_axi.awid;
            w_len         <= s_axi.awlen;
            w_fixed       <= (s_axi.awburst == BURST_FIXED);
            w_idx         <= word_idx(s_axi.awaddr);
            w_dec         <= out_of_range(s_axi.awaddr);
            w_cnt         <= '0;
            w_over        <= 1'b0;
            w_state       <= W_DATA;
          end else begin
            s_axi.awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (s_axi.wvalid && s_axi.wready) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_idx <= w_idx + 1'b1;
            if (s_axi.wlast) begin
              s_axi.wready <= 1'b0;
              s_axi.bvalid <= 1'b1;
              s_axi.bresp  <= w_dec ? RESP_DECERR :
                              (w_over || w_cnt != w_len) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else if (w_cnt == w_len) begin
              // beat count past awlen+1 stays flagged even if the counter wraps
              w_over <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid  <= 1'b0;
            s_axi.awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rid     <= '0;
      s_axi.rresp   <= RESP_OKAY;
      s_axi.rlast   <= 1'b0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
      r_dec         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi.arvalid && s_axi.arready) begin
            s_axi.arready <= 1'b0;
            s_axi.rvalid  <= 1'b1;
            s_axi.rid     <= s_axi.arid;
            s_axi.rresp   <= out_of_range(s_axi.araddr) ? RESP_DECERR : RESP_OKAY;
            s_axi.rlast   <= (s_axi.arlen == 8'd0);
            r_len         <= s_axi.arlen;
            r_cnt         <= '0;
            r_fixed       <= (s_axi.arburst == BURST_FIXED);
            r_idx         <= word_idx(s_axi.araddr);
            r_dec         <= out_of_range(s_axi.araddr);
            r_state       <= R_DATA;
          end else begin
            s_axi.arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rvalid && s_axi.rready) begin
            if (s_axi.rlast) begin
              s_axi.rvalid  <= 1'b0;
              s_axi.rlast   <= 1'b0;
              s_axi.arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_cnt       <= r_cnt + 8'd1;
              s_axi.rlast <= (r_cnt + 8'd1 == r_len);
              if (!r_fixed) r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.rdata = (s_axi.rvalid && !r_dec) ? mem_rdata : '0;
endmodule

// File: doc/axi_slave_ram.md
Name: axi_slave_ram

Overview:
- AXI4 full-protocol slave (responder) with an internal word-addressed RAM.
- It is the far end for the team's AXI master burst engine and is used as the bench target and as on-chip scratch memory.
- Write path (AW/W/B) and read path (AR/R) are independent FSMs, each with one outstanding transaction.
- Supports FIXED and INCR bursts, byte strobes, and DECERR/SLVERR reporting.

Parameters:
S_BASE_ADDR, 32'h4000_0000, byte address of RAM word 0.
S_ID_WIDTH, 1, width of AWID/BID/ARID/RID.
S_ADDR_WIDTH, 32, byte address width.
S_DATA_WIDTH, 32, data width; must be 32 or 64.
S_MEM_DEPTH, 256, RAM depth in words; must be a power of two.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
s_axi_awid  in  S_ID_WIDTH  write ID
s_axi_awaddr  in  S_ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats minus 1
s_axi_awsize  in  3  must equal log2(S_DATA_WIDTH/8); value is not checked
s_axi_awburst  in  2  burst type
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  S_DATA_WIDTH  write data
s_axi_wstrb  in  S_DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  S_ID_WIDTH  captured AWID
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  S_ID_WIDTH  read ID
s_axi_araddr  in  S_ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  as awsize
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  S_ID_WIDTH  captured ARID
s_axi_rdata  out  S_DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
Lock, cache, prot, qos and user signals are not ported.

Behaviour:
- Reset values:
  - All outputs are registered and reset to 0, including awready and arready.
  - awready and arready go to 1 on the first clk edge after rst deasserts.
  - RAM contents are not reset.
- Word index: idx = (addr - S_BASE_ADDR) >> log2(S_DATA_WIDTH/8), truncated to log2(S_MEM_DEPTH) bits. The low address bits are ignored (no unaligned support).
- Range check, done on the start address only:
  - In range means addr - S_BASE_ADDR < S_MEM_DEPTH*S_DATA_WIDTH/8.
  - Out of range marks the whole burst DECERR (2'b11).
- Burst types:
  - FIXED (00) keeps idx for every beat.
  - INCR (01), and also 10 and 11, increments idx by 1 per beat.
  - idx wraps modulo S_MEM_DEPTH; no 4KB check.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On awvalid&awready, capture awid/len/burst/idx and the DECERR flag, set awready=0 and wready=1, then go to W_DATA.
  - W_DATA: on each wvalid&wready, write the bytes whose wstrb bit is 1 to mem[idx] (no write if DECERR), increment beat_cnt, and step idx.
  - W_DATA on a beat with wlast=1: wready=0, bvalid=1, go to W_RESP.
  - bresp priority: DECERR; otherwise SLVERR (2'b10) if beats != awlen+1; otherwise OKAY.
  - Extra beats without wlast are accepted and written; that burst gets SLVERR.
  - W_RESP: hold bvalid, bid and bresp until bready. On bvalid&bready, set bvalid=0, awready=1, go to W_IDLE.
  - Minimum write burst time: 1 AW cycle + N W cycles + 1 B cycle; awready returns the cycle after the B handshake.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On arvalid&arready, capture arid/len/burst/idx and the DECERR flag, set arready=0, go to R_DATA.
  - R_DATA: rvalid=1 starting the cycle after the AR handshake.
  - rdata = mem[idx], or 0 if DECERR. rresp = DECERR or OKAY. rlast=1 when beat_cnt == arlen.
  - rdata, rresp and rlast stay stable while rvalid & !rready.
  - On rvalid&rready: advance idx and load the next beat with no bubble, giving 1 beat per cycle under continuous rready.
  - On the rlast handshake: rvalid=0, arready=1, go to R_IDLE.
- Simultaneous write and read to the same word in the same cycle: the R beat presented that cycle shows the old data. The new data is visible from the next cycle.
- awlen/arlen = 0 gives a single beat with rlast=1 on that beat.
- rst asserted mid-burst: both FSMs go to idle immediately and all outputs go to 0. Any partial write already stored stays in RAM.

Decomposition:
- Package axi_pkg holds:
  - burst constants BURST_FIXED=2'b00 and BURST_INCR=2'b01;
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - write and read FSM state encodings;
  - a clog2 function.
- Sub-module axi_slave_ram_mem: simple dual-port RAM with one write port (byte enables) and one registered-address read port, sized S_MEM_DEPTH x S_DATA_WIDTH.

Test Plan:
1. Write INCR awaddr=0x4000_0004, awlen=15, data 0x100+i, wstrb=4'hF; then read the same burst -> bresp=00, 16 R beats 0x100..0x10F, rlast only on beat 15, rresp=00.
2. Write word 0x4000_0000 = 0xAABBCCDD, then single beat wstrb=4'b0101 data 0x11223344; read -> 0xAA22CC44.
3. awaddr=0x4000_0400 (just past 256 words), awlen=3 -> bresp=11, RAM unchanged; araddr=0x3FFF_FFFC -> 1 beat rdata=0, rresp=11, rlast=1.
4. awlen=3 with wlast on beat 2 -> bresp=10. Then FIXED burst awlen=3 to 0x4000_0010 with data 1,2,3,4 -> mem[4]=4.
5. Random rready and bready stalls during a 16-beat read -> rdata/rlast stable while stalled, beats in order, awready/arready held 0 until the burst completes.
6. rst pulsed low at beat 5 of a 16-beat write -> all outputs 0 during reset, awready=1 one cycle after release, beats 0-4 present in RAM.
